// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : instruction fetch stage with an in-order memory request queue
// and MEM-stage redirect flush.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_next_pc
);

  localparam int PW = $clog2(QDEPTH);
  // Counts reach QDEPTH and their sum reaches 2*QDEPTH.
  localparam int CW = PW + 2;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       ins_q [QDEPTH];
  logic [31:0]       ins_d [QDEPTH];
  logic [31:0]       npc_q [QDEPTH];
  logic [31:0]       npc_d [QDEPTH];
  logic [QDEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

  logic              pop;
  logic              alloc_fire;
  logic [CW-1:0]     nfilled;
  logic [CW-1:0]     unfilled;
  logic [CW-1:0]     credit;

  assign out_valid   = reset_n && (alloc_cnt_q != '0) && filled_q[head_q];
  assign out_ins     = out_valid ? ins_q[head_q] : 32'h0;
  assign out_next_pc = out_valid ? npc_q[head_q] : 32'h0;
  assign pop         = out_valid && out_ready;
  assign imem_addr   = fetch_pc_q;

  // The popped slot is handed back to the request side in the same cycle.
  assign credit     = alloc_cnt_q - CW'(pop) + drop_cnt_q;
  assign imem_req   = reset_n && !redirect && (credit < CW'(QDEPTH));
  assign alloc_fire = imem_req && imem_ack;

  always_comb begin
    nfilled = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      nfilled = nfilled + CW'(filled_q[i]);
    end
    unfilled = alloc_cnt_q - nfilled;

    fetch_pc_d  = fetch_pc_q;
    ins_d       = ins_q;
    npc_d       = npc_q;
    filled_d    = filled_q;
    head_d      = head_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (redirect) begin
      // Every unfilled entry still owes a response; one arriving now is eaten.
      fetch_pc_d  = redirect_pc;
      filled_d    = '0;
      head_d      = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      alloc_cnt_d = '0;
      drop_cnt_d  = drop_cnt_q + unfilled - CW'(imem_rvalid);
    end else begin
      if (imem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          ins_d[fill_ptr_q]    = imem_rdata;
          filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d           = fill_ptr_q + PW'(1);
        end
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      if (alloc_fire) begin
        npc_d[alloc_ptr_q]    = fetch_pc_q + 32'd4;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      alloc_cnt_d = alloc_cnt_q + CW'(alloc_fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      filled_q    <= '0;
      head_q      <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Payload storage is qualified by filled_q, so it needs no reset.
  always_ff @(posedge clk) begin
    ins_q <= ins_d;
    npc_q <= npc_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed and randomized checks of fetch_unit against a
// queue-based reference model with a variable-latency memory.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_next_pc;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_ins(out_ins),
    .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          ack_pct, ready_pct, lat_lo, lat_hi;
  bit          redir_now;
  logic [31:0] redir_pc_now;

  // Memory: in-order responses, each with its due cycle.
  int          mq_due[$];
  logic [31:0] mq_data[$];

  // Model: PCs of live entries in order; words already returned for them.
  logic [31:0] m_pc;
  logic [31:0] e_pc[$];
  logic [31:0] e_ins[$];
  int          e_drop;

  bit          rv, e_valid, e_req, e_pop;
  logic [31:0] e_ins_o, e_npc;

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task begin_cycle();
    rv          = (mq_due.size() > 0) && (mq_due[0] == cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mq_data[0] : $urandom();
    imem_ack    = ($urandom_range(99) < ack_pct);
    out_ready   = ($urandom_range(99) < ready_pct);
    redirect    = redir_now;
    redirect_pc = redir_pc_now;

    e_valid = (e_ins.size() > 0);
    e_ins_o = e_valid ? e_ins[0] : 32'h0;
    e_npc   = e_valid ? e_pc[0] + 32'd4 : 32'h0;
    e_pop   = e_valid && out_ready;
    e_req   = !redir_now && ((e_pc.size() - (e_pop ? 1 : 0) + e_drop) < QD);

    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_ins", out_ins, e_ins_o);
    chk("out_next_pc", out_next_pc, e_npc);
  endtask

  task end_cycle();
    int due;
    if (redir_now) begin
      e_drop = e_drop + (e_pc.size() - e_ins.size()) - (rv ? 1 : 0);
      e_pc.delete();
      e_ins.delete();
      m_pc = redir_pc_now;
    end else begin
      if (rv) begin
        if (e_drop > 0) e_drop--;
        else e_ins.push_back(mq_data[0]);
      end
      if (e_pop) begin
        e_pc.delete(0);
        e_ins.delete(0);
      end
    end
    if (rv) begin
      mq_due.delete(0);
      mq_data.delete(0);
    end
    if (!redir_now && e_req && imem_ack) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
      mq_due.push_back(due);
      mq_data.push_back(m_pc ^ XK);
      e_pc.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    redir_now = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ins", out_ins, 32'h0);
      chk("rst_npc", out_next_pc, 32'h0);
      @(posedge clk);
      #1;
    end
    mq_due.delete();
    mq_data.delete();
    e_pc.delete();
    e_ins.delete();
    e_drop    = 0;
    m_pc      = RPC;
    cyc       = 0;
    redir_now = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    redir_now    = 1'b0;
    redir_pc_now = 32'h0;
    reset_n      = 1'b0;
    @(posedge clk);
    #1;

    // Straight-line fetch, 1-cycle memory, then a 6-cycle stall.
    do_reset();
    ack_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      chk("p1_addr", imem_addr, RPC + 32'(4 * k));
      chk("p1_valid", 32'(out_valid), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2) chk("p1_npc", out_next_pc, RPC + 32'(4 * (k - 1)));
      end_cycle();
    end
    ready_pct = 0;
    for (int h = 0; h < 6; h++) begin
      begin_cycle();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_npc", out_next_pc, 32'h0000_012C);
      chk("bp_ins", out_ins, 32'hA5A5_0128);
      chk("bp_req", 32'(imem_req), (h < 2) ? 32'h1 : 32'h0);
      end_cycle();
    end
    ready_pct = 100;
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      end_cycle();
    end

    // Redirect with three responses owed by a 3-cycle memory.
    do_reset();
    ack_pct = 100; ready_pct = 100; lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 10; k++) begin
      redir_now    = (k == 3);
      redir_pc_now = 32'h0000_0400;
      begin_cycle();
      if (k == 4) chk("rd3_addr", imem_addr, 32'h0000_0400);
      if (k >= 4 && k <= 7) chk("rd3_gap", 32'(out_valid), 32'h0);
      if (k == 8) begin
        chk("rd3_valid", 32'(out_valid), 32'h1);
        chk("rd3_npc", out_next_pc, 32'h0000_0404);
        chk("rd3_ins", out_ins, 32'hA5A5_0400);
      end
      end_cycle();
    end

    // Redirect coinciding with a response and a pop.
    do_reset();
    ack_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 10; k++) begin
      redir_now    = (k == 5);
      redir_pc_now = 32'h0000_0800;
      begin_cycle();
      if (k == 5) chk("rdp_pop", 32'(out_valid), 32'h1);
      if (k == 6) chk("rdp_addr", imem_addr, 32'h0000_0800);
      if (k == 6 || k == 7) chk("rdp_gap", 32'(out_valid), 32'h0);
      if (k == 8) begin
        chk("rdp_valid", 32'(out_valid), 32'h1);
        chk("rdp_npc", out_next_pc, 32'h0000_0804);
        chk("rdp_ins", out_ins, 32'hA5A5_0800);
      end
      end_cycle();
    end

    // Address wrap at the top of the 32-bit space.
    do_reset();
    ack_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 7; k++) begin
      redir_now    = (k == 0);
      redir_pc_now = 32'hFFFF_FFF8;
      begin_cycle();
      if (k == 1) chk("wrap_a1", imem_addr, 32'hFFFF_FFF8);
      if (k == 2) chk("wrap_a2", imem_addr, 32'hFFFF_FFFC);
      if (k == 3) chk("wrap_a3", imem_addr, 32'h0000_0000);
      if (k == 3) chk("wrap_n1", out_next_pc, 32'hFFFF_FFFC);
      if (k == 3) chk("wrap_i1", out_ins, 32'h5A5A_FFF8);
      if (k == 4) chk("wrap_n2", out_next_pc, 32'h0000_0000);
      if (k == 5) chk("wrap_n3", out_next_pc, 32'h0000_0004);
      end_cycle();
    end

    // Random ack stalls, 1..4-cycle latency, backpressure and redirects.
    do_reset();
    ack_pct = 70; ready_pct = 70; lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 10000; k++) begin
      r            = $urandom();
      redir_now    = ($urandom_range(99) < 3);
      redir_pc_now = r & 32'hFFFF_FFFC;
      begin_cycle();
      end_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 5-stage pipeline. It owns the fetch PC and issues in-order read requests to instruction memory over a req/ack handshake with variable response latency. Returned words are buffered in a small fetch queue and presented, with their PC+4, to the IF/ID stage register under a valid/ready handshake. A taken branch or jump resolved in MEM redirects it, which flushes all queued and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 4, fetch-queue entries; power of 2, ≥2

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  request accepted this cycle; meaningful only with imem_req
- imem_rvalid  in  1  read data returned; in order, ≥1 cycle after its ack
- imem_rdata  in  32  instruction word
- redirect  in  1  taken branch or jump from MEM
- redirect_pc  in  32  redirect target
- out_ready  in  1  IF/ID register write enable
- out_valid  out  1  out_ins and out_next_pc valid
- out_ins  out  32  instruction; 0 (NOP) when !out_valid
- out_next_pc  out  32  fetch address + 4; 0 when !out_valid

## Operation
- State:
  - fetch_pc (32 bits).
  - Circular queue of QDEPTH entries, each {next_pc, ins, filled}.
  - Head, alloc and fill pointers.
  - alloc_cnt: entries allocated, 0..QDEPTH.
  - drop_cnt: flushed responses still owed by memory, 0..QDEPTH.
- Issue:
  - imem_req = !redirect && (alloc_cnt − pop + drop_cnt < QDEPTH).
  - pop = out_valid && out_ready.
  - imem_addr = fetch_pc.
  - On req && ack: allocate the entry at the alloc pointer, store next_pc = fetch_pc + 4, clear filled, and set fetch_pc += 4. Wrap is mod 2^32.
- Response:
  - When drop_cnt > 0, imem_rvalid decrements drop_cnt and the data is discarded.
  - Otherwise rdata is written into the entry at the fill pointer, filled is set, and the fill pointer advances.
- Output: out_valid = head entry allocated and filled. Pop advances head and decrements alloc_cnt.
- Redirect has priority over every other event in its cycle:
  - fetch_pc ← redirect_pc.
  - All entries are cleared; head, alloc and fill pointers are reset to 0; alloc_cnt ← 0.
  - drop_cnt ← drop_cnt + (allocated-but-unfilled entries) − (imem_rvalid ? 1 : 0). An rvalid in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - A pop in the same cycle still counts as consumed downstream. The IF/ID register is flushed separately by its owner.
- Simultaneous pop and allocate (no redirect): alloc_cnt is unchanged.
- Invariant: alloc_cnt + drop_cnt ≤ QDEPTH. Memory never returns more responses than acks, so drop_cnt never underflows.

## Timing
- Reset values: fetch_pc = RESET_PC; alloc_cnt = drop_cnt = 0; all pointers 0; all filled = 0. During reset, imem_req = 0, out_valid = 0, out_ins = 0 and out_next_pc = 0.
- Reset asserted mid-operation discards all queued and in-flight state. Any response that arrives later is ignored only if the memory is reset too; the system resets both together.
- First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.
- Minimum latency:
  - ack in cycle T, rvalid in T+1, out_valid in T+2.
  - Entry freed by the pop at the T+2 edge.
  - Credit is returned combinationally in the pop cycle.
- Throughput: with 1-cycle memory and out_ready held high, one instruction per cycle sustained for QDEPTH ≥ 3.
- Backpressure: with out_ready = 0, outputs hold stable. Requests stop once alloc_cnt + drop_cnt = QDEPTH.
- Redirect in cycle R:
  - First request to redirect_pc in R+1.
  - out_valid = 0 in R+1.
  - With 1-cycle memory and no owed drops, the first target instruction is valid in R+3.

## Test plan
- Reset, then straight-line fetch with RESET_PC = 0x100 and a 1-cycle memory returning addr ^ 0xA5A5_0000:
  - imem_addr = 0x100, 0x104, 0x108…
  - out_valid from the 3rd cycle after reset, out_next_pc = 0x104, 0x108…, no gaps.
- Backpressure: hold out_ready = 0 for 6 cycles mid-stream.
  - Exactly 4 requests are outstanding or queued, then imem_req = 0.
  - Outputs stay stable.
  - After release, words arrive in order with no loss or duplication.
- Redirect with 3 responses in flight on a 3-cycle-latency memory, redirect_pc = 0x400:
  - 3 responses are discarded.
  - The next out_valid carries the word from 0x400 with out_next_pc = 0x404.
- Redirect in the same cycle as imem_rvalid and a pop:
  - That rvalid is dropped.
  - drop_cnt is updated correctly.
  - No stale instruction appears after the redirect.
- Random ack stalls and 1–4-cycle response latency, plus random out_ready, over 10k cycles checked against a reference PC model:
  - Every output matches the model.
  - alloc_cnt + drop_cnt never exceeds QDEPTH.
- Wrap: RESET_PC = 0xFFFF_FFF8.
  - Fetches go to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - out_next_pc values are 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
